// File: rtl/clk_gate_ctrl.sv
// Idle-timeout enable generator for a downstream clock-gating stage.
// Keeps the gated domain enabled while requests arrive, waits out a fixed
// wake period before acknowledging, and gates off after a programmable
// idle period. Counts gate-off events with a saturating 16-bit counter.
module clk_gate_ctrl #(
    parameter int unsigned IDLE_CYCLES      = 8,
    parameter int unsigned WAKE_CYCLES      = 2,
    // Reset value of the gate-off counter; 0 in normal use.
    parameter logic [15:0] GATE_EVENTS_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        force_on,
    output logic        en,
    output logic        ack,
    output logic [1:0]  state,
    output logic [15:0] gate_events
);

    localparam int unsigned IW = $clog2(IDLE_CYCLES) + 1;
    localparam int unsigned WW = $clog2(WAKE_CYCLES) + 1;

    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2,
        ST_IDLE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          en_q, en_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [WW-1:0] wake_cnt_q, wake_cnt_d;
    logic [15:0]   gate_events_q, gate_events_d;

    logic go;

    assign go = req | force_on;

    // Next-state, counter and telemetry logic for the power FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        idle_cnt_d    = idle_cnt_q;
        wake_cnt_d    = wake_cnt_q;
        gate_events_d = gate_events_q;

        case (state_q)
            ST_OFF: begin
                if (go) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                // The wake period always runs to completion so the gated
                // clock is stable before anything is acknowledged.
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q + WW'(1);
                end
            end
            ST_RUN: begin
                if (!go) begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = '0;
                end
            end
            ST_IDLE: begin
                // A request in the last idle cycle wins over the gate-off.
                if (go) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d = ST_OFF;
                    if (gate_events_q != 16'hFFFF) begin
                        gate_events_d = gate_events_q + 16'd1;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Enable is registered from the next state so it changes on the same
    // edge as the state register and is glitch-free at the gating stage.
    assign en_d = (state_d != ST_OFF);

    // State, counter and enable registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_OFF;
            en_q          <= 1'b0;
            idle_cnt_q    <= '0;
            wake_cnt_q    <= '0;
            gate_events_q <= GATE_EVENTS_INIT;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            en_q          <= en_d;
            idle_cnt_q    <= idle_cnt_d;
            wake_cnt_q    <= wake_cnt_d;
            gate_events_q <= gate_events_d;
        end
    end

    assign en          = en_q;
    assign ack         = (state_q == ST_RUN) & req;
    assign state       = state_q;
    assign gate_events = gate_events_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl. The driver applies one input vector
// per cycle and queues the hand-computed outputs for that cycle; a monitor
// on the falling edge pops and compares them. A second instance with short
// periods and a preloaded counter exercises gate_events saturation.
module tb_clk_gate_ctrl;

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_WAKE = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd3;

    typedef struct {
        bit          sel;
        logic        en;
        logic        ack;
        logic [1:0]  st;
        logic [15:0] gev;
        string       nm;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req, force_on;
    logic        en, ack;
    logic [1:0]  state;
    logic [15:0] gate_events;

    logic        req2, force2;
    logic        en2, ack2;
    logic [1:0]  state2;
    logic [15:0] gate_events2;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    clk_gate_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .force_on    (force_on),
        .en          (en),
        .ack         (ack),
        .state       (state),
        .gate_events (gate_events)
    );

    clk_gate_ctrl #(
        .IDLE_CYCLES      (1),
        .WAKE_CYCLES      (1),
        .GATE_EVENTS_INIT (16'hFFFC)
    ) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .req         (req2),
        .force_on    (force2),
        .en          (en2),
        .ack         (ack2),
        .state       (state2),
        .gate_events (gate_events2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [19:0] act, input logic [19:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got en=%b ack=%b state=%0d gev=%h, want en=%b ack=%b state=%0d gev=%h",
                     nm, act[19], act[18], act[17:16], act[15:0],
                     want[19], want[18], want[17:16], want[15:0]);
        end
    endtask

    // Monitor: compare the queued expectation against the live outputs.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t        e;
            logic [19:0] act;
            e = exp_q.pop_front();
            act = e.sel ? {en2, ack2, state2, gate_events2}
                        : {en, ack, state, gate_events};
            check(e.nm, act, {e.en, e.ack, e.st, e.gev});
        end
    end

    task automatic push(input bit sel, input logic e, input logic a,
                        input logic [1:0] st, input logic [15:0] g, input string nm);
        exp_t x;
        x.sel = sel; x.en = e; x.ack = a; x.st = st; x.gev = g; x.nm = nm;
        exp_q.push_back(x);
    endtask

    // Drive one cycle on the main instance and queue that cycle's outputs.
    task automatic step(input logic r, input logic f, input logic [1:0] st,
                        input logic e, input logic a, input logic [15:0] g, input string nm);
        req = r;
        force_on = f;
        push(1'b0, e, a, st, g, nm);
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle on the saturation instance.
    task automatic step2(input logic r, input logic [1:0] st, input logic e,
                         input logic a, input logic [15:0] g, input string nm);
        req2 = r;
        push(1'b1, e, a, st, g, nm);
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges; outputs must clear before the next edge.
    task automatic areset(input string nm);
        #1;
        rst = 1'b0;
        push(1'b0, 1'b0, 1'b0, S_OFF, 16'h0000, nm);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sat_tab [6];
        sat_tab = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};

        rst = 1'b0; req = 1'b0; force_on = 1'b0; req2 = 1'b0; force2 = 1'b0;
        @(posedge clk);
        #1;
        // Held in reset with req high: nothing moves.
        step(1, 0, S_OFF, 0, 0, 16'd0, "reset_hold_a");
        step(1, 0, S_OFF, 0, 0, 16'd0, "reset_hold_b");
        rst = 1'b1;

        // Wake-up: en after the sampling edge, RUN two edges later.
        step(0, 0, S_OFF,  0, 0, 16'd0, "off_quiet");
        step(1, 0, S_OFF,  0, 0, 16'd0, "req_first");
        step(1, 0, S_WAKE, 1, 0, 16'd0, "wake_0");
        step(1, 0, S_WAKE, 1, 0, 16'd0, "wake_1");
        step(1, 0, S_RUN,  1, 1, 16'd0, "run_ack");
        step(1, 0, S_RUN,  1, 1, 16'd0, "run_ack_hold");

        // Idle timeout: eight IDLE cycles, then gate off.
        step(0, 0, S_RUN, 1, 0, 16'd0, "run_drop");
        for (int i = 0; i < 8; i++) step(0, 0, S_IDLE, 1, 0, 16'd0, "idle_wait");
        step(0, 0, S_OFF, 0, 0, 16'd1, "gated_off");

        // Wake with req dropped during WAKE still completes.
        step(1, 0, S_OFF,  0, 0, 16'd1, "wake_req");
        step(0, 0, S_WAKE, 1, 0, 16'd1, "wake_noreq_a");
        step(0, 0, S_WAKE, 1, 0, 16'd1, "wake_noreq_b");
        step(0, 0, S_RUN,  1, 0, 16'd1, "run_noreq");

        // Request in the final idle cycle rescues the domain.
        for (int i = 0; i < 7; i++) step(0, 0, S_IDLE, 1, 0, 16'd1, "idle_pre_last");
        step(1, 0, S_IDLE, 1, 0, 16'd1, "idle_last_go");
        step(0, 0, S_RUN,  1, 0, 16'd1, "rescued_run");

        // Request mid-idle returns to RUN; a fresh full timeout follows.
        for (int i = 0; i < 3; i++) step(0, 0, S_IDLE, 1, 0, 16'd1, "idle_pre_mid");
        step(1, 0, S_IDLE, 1, 0, 16'd1, "idle_mid_go");
        step(1, 0, S_RUN,  1, 1, 16'd1, "rerun_ack");
        step(0, 0, S_RUN,  1, 0, 16'd1, "rerun_drop");
        for (int i = 0; i < 8; i++) step(0, 0, S_IDLE, 1, 0, 16'd1, "idle_full");
        step(0, 0, S_OFF, 0, 0, 16'd2, "gated_off2");

        // force_on keeps the domain up without acknowledging.
        step(0, 1, S_OFF,  0, 0, 16'd2, "force_start");
        step(0, 1, S_WAKE, 1, 0, 16'd2, "force_wake_a");
        step(0, 1, S_WAKE, 1, 0, 16'd2, "force_wake_b");
        for (int i = 0; i < 50; i++) step(0, 1, S_RUN, 1, 0, 16'd2, "force_hold");
        step(1, 1, S_RUN, 1, 1, 16'd2, "force_req_ack");
        step(0, 0, S_RUN, 1, 0, 16'd2, "force_release");

        // Asynchronous reset mid-IDLE clears everything, counter included.
        step(0, 0, S_IDLE, 1, 0, 16'd2, "idle_pre_rst_a");
        step(0, 0, S_IDLE, 1, 0, 16'd2, "idle_pre_rst_b");
        areset("rst_mid_idle");
        step(1, 0, S_OFF,  0, 0, 16'd0, "post_rst_req");
        step(1, 0, S_WAKE, 1, 0, 16'd0, "post_rst_wake_a");
        step(1, 0, S_WAKE, 1, 0, 16'd0, "post_rst_wake_b");
        step(1, 0, S_RUN,  1, 1, 16'd0, "post_rst_run");

        // Reset in RUN with req high drops ack immediately.
        areset("rst_mid_run");

        // Reset mid-WAKE, then a full two-cycle wake again.
        step(1, 0, S_OFF,  0, 0, 16'd0, "rewake_req");
        step(1, 0, S_WAKE, 1, 0, 16'd0, "rewake_wake");
        areset("rst_mid_wake");
        step(1, 0, S_OFF,  0, 0, 16'd0, "after_rst_req");
        step(1, 0, S_WAKE, 1, 0, 16'd0, "after_rst_wake_a");
        step(1, 0, S_WAKE, 1, 0, 16'd0, "after_rst_wake_b");
        step(1, 0, S_RUN,  1, 1, 16'd0, "after_rst_run");
        req = 1'b0;

        // Saturation on the short-period instance preloaded near the top.
        for (int i = 0; i < 5; i++) begin
            step2(1, S_OFF,  0, 0, sat_tab[i], "sat_off");
            step2(0, S_WAKE, 1, 0, sat_tab[i], "sat_wake");
            step2(0, S_RUN,  1, 0, sat_tab[i], "sat_run");
            step2(0, S_IDLE, 1, 0, sat_tab[i], "sat_idle");
        end
        step2(0, S_OFF, 0, 0, sat_tab[5], "sat_hold");

        @(posedge clk);
        #1;
        check("queue_drained", 20'(exp_q.size()), 20'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
